// File: rtl/lcd_hd44780_responder_pkg.sv
// lcd_hd44780_responder_pkg: FSM states, instruction mask/match constants and address-counter helpers
package lcd_hd44780_responder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} lcd_state_e;
  localparam logic [7:0] DDRAM_SPACE = 8'h20;
  localparam logic [7:0] M_DDRAM = 8'h80, V_DDRAM = 8'h80;
  localparam logic [7:0] M_SHIFT = 8'hF0, V_SHIFT = 8'h10;
  localparam logic [7:0] M_DISP  = 8'hF8, V_DISP  = 8'h08;
  localparam logic [7:0] M_ENTRY = 8'hFC, V_ENTRY = 8'h04;
  localparam logic [7:0] M_HOME  = 8'hFE, V_HOME  = 8'h02;
  localparam logic [7:0] M_CLEAR = 8'hFF, V_CLEAR = 8'h01;
  function automatic logic hit(input logic [7:0] d, input logic [7:0] m, input logic [7:0] v);
    return (d & m) == v;
  endfunction
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    return inc ? (ac == 7'h0F ? 7'h40 : ac == 7'h4F ? 7'h00 : ac + 7'd1)
               : (ac == 7'h00 ? 7'h4F : ac == 7'h40 ? 7'h0F : ac - 7'd1);
  endfunction
endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// lcd_hd44780_responder_if: HD44780 parallel bus between controller (master) and panel (slave)
interface lcd_hd44780_responder_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_dq;
  modport master (output lcd_data, lcd_rs, lcd_rw, lcd_e, input lcd_dq);
  modport slave (input lcd_data, lcd_rs, lcd_rw, lcd_e, output lcd_dq);
endinterface

// File: rtl/lcd_hd44780_responder_ddram.sv
// lcd_hd44780_responder_ddram: 32x8 display RAM, reset-filled with spaces, one write port, registered read port
module lcd_hd44780_responder_ddram
  import lcd_hd44780_responder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char
);
  logic [7:0] mem_q [32];
  logic [7:0] mem_d [32];
  logic [7:0] rd_q, rd_d;
  // next memory image and read data
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    rd_d = mem_q[rd_idx];
  end
  // storage; reset fills every cell with a space
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= DDRAM_SPACE;
      rd_q <= 8'h00;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end
  assign rd_char = rd_q;
endmodule

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: HD44780 panel-side responder with DDRAM mirror; LCD_BUSY_MODEL_EN enables busy timing
module lcd_hd44780_responder
  import lcd_hd44780_responder_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned CMD_US   = 40,
  parameter int unsigned CLEAR_US = 1640
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  lcd_hd44780_responder_if.slave        lcd,
  input  logic [4:0]                    i_rd_idx,
  output logic [7:0]                    o_rd_char,
  output logic                          o_busy,
  output logic                          o_evt_valid,
  output logic                          o_evt_rs,
  output logic [7:0]                    o_evt_byte,
  output logic                          o_disp_on,
  output logic                          o_err
);
`ifdef LCD_BUSY_MODEL_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif
  localparam longint CMD_CYC = longint'(CMD_US) * longint'(CLK_FREQ) / 1_000_000;
  localparam longint CLR_CYC = longint'(CLEAR_US) * longint'(CLK_FREQ) / 1_000_000;
  localparam logic [31:0] CMD_LD = 32'((CMD_CYC > 0) ? CMD_CYC - 1 : 0);
  localparam logic [31:0] CLR_LD = 32'((CLR_CYC > 0) ? CLR_CYC - 1 : 0);

  lcd_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d, ld;
  logic [4:0]  fill_q, fill_d;
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d, disp_q, disp_d, err_q, err_d, busy_q, busy_d, e_q;
  logic        evt_v_q, evt_v_d, evt_rs_q, evt_rs_d;
  logic [7:0]  evt_byte_q, evt_byte_d;
  logic        pend_v_q, pend_v_d, pend_rs_q, pend_rs_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        fall, wr, x_v, x_rs, is_clr, we;
  logic [7:0]  x_data, wdata;
  logic [4:0]  waddr;

  assign fall   = e_q & ~lcd.lcd_e;
  assign wr     = fall & ~lcd.lcd_rw;
  // without the busy model a transfer held during a clear fill takes precedence once IDLE
  assign x_v    = wr | (!BUSY_EN && pend_v_q);
  assign x_rs   = pend_v_q ? pend_rs_q : lcd.lcd_rs;
  assign x_data = pend_v_q ? pend_data_q : lcd.lcd_data;
  assign is_clr = !x_rs && hit(x_data, M_CLEAR, V_CLEAR);

  // decode, address counter, busy counter and clear fill
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fill_d = fill_q;
    ac_d = ac_q;
    id_d = id_q;
    disp_d = disp_q;
    err_d = err_q;
    evt_v_d = 1'b0;
    evt_rs_d = evt_rs_q;
    evt_byte_d = evt_byte_q;
    pend_v_d = pend_v_q;
    pend_rs_d = pend_rs_q;
    pend_data_d = pend_data_q;
    we = 1'b0;
    waddr = {ac_q[6], ac_q[3:0]};
    wdata = x_data;
    ld = CMD_LD;
    case (state_q)
      IDLE: begin
        pend_v_d = !BUSY_EN && pend_v_q && wr;
        if (pend_v_q && wr) begin
          pend_rs_d = lcd.lcd_rs;
          pend_data_d = lcd.lcd_data;
        end
        if (x_v && (x_rs || x_data != 8'h00)) begin
          evt_v_d = 1'b1;
          evt_rs_d = x_rs;
          evt_byte_d = x_data;
          if (x_rs) begin
            we = 1'b1;
            ac_d = ac_step(ac_q, id_q);
          end else if (hit(x_data, M_DDRAM, V_DDRAM)) begin
            ac_d = {x_data[6], 2'b00, x_data[3:0]};
            err_d = err_q | (x_data[5:4] != 2'b00);
          end else if (hit(x_data, M_SHIFT, V_SHIFT)) begin
            ac_d = x_data[3] ? ac_q : ac_step(ac_q, x_data[2]);
          end else if (hit(x_data, M_DISP, V_DISP)) begin
            disp_d = x_data[2];
          end else if (hit(x_data, M_ENTRY, V_ENTRY)) begin
            id_d = x_data[1];
          end else if (hit(x_data, M_HOME, V_HOME) || is_clr) begin
            ac_d = is_clr ? ac_q : 7'h00;
            ld = CLR_LD;
          end
          cnt_d = ld;
          fill_d = 5'd0;
          state_d = is_clr ? CLEAR : (BUSY_EN ? BUSY : IDLE);
        end
      end
      BUSY: begin
        state_d = (cnt_q == 32'd0) ? IDLE : BUSY;
        cnt_d = (cnt_q == 32'd0) ? cnt_q : cnt_q - 32'd1;
        err_d = err_q | wr;
      end
      CLEAR: begin
        we = 1'b1;
        waddr = fill_q;
        wdata = DDRAM_SPACE;
        fill_d = fill_q + 5'd1;
        cnt_d = (cnt_q == 32'd0) ? cnt_q : cnt_q - 32'd1;
        err_d = err_q | (BUSY_EN && wr);
        if (!BUSY_EN && wr && !pend_v_q) begin
          pend_v_d = 1'b1;
          pend_rs_d = lcd.lcd_rs;
          pend_data_d = lcd.lcd_data;
        end
        if (fill_q == 5'd31) begin
          ac_d = 7'h00;
          id_d = 1'b1;
          state_d = (BUSY_EN && cnt_q != 32'd0) ? BUSY : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = BUSY_EN && (state_d != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= 32'd0;
      fill_q <= 5'd0;
      ac_q <= 7'h00;
      id_q <= 1'b1;
      disp_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      e_q <= 1'b0;
      evt_v_q <= 1'b0;
      evt_rs_q <= 1'b0;
      evt_byte_q <= 8'h00;
      pend_v_q <= 1'b0;
      pend_rs_q <= 1'b0;
      pend_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      ac_q <= ac_d;
      id_q <= id_d;
      disp_q <= disp_d;
      err_q <= err_d;
      busy_q <= busy_d;
      e_q <= lcd.lcd_e;
      evt_v_q <= evt_v_d;
      evt_rs_q <= evt_rs_d;
      evt_byte_q <= evt_byte_d;
      pend_v_q <= pend_v_d;
      pend_rs_q <= pend_rs_d;
      pend_data_q <= pend_data_d;
    end
  end

  lcd_hd44780_responder_ddram u_ddram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_idx  (i_rd_idx),
    .rd_char (o_rd_char)
  );

  assign lcd.lcd_dq  = (lcd.lcd_e && lcd.lcd_rw && !lcd.lcd_rs) ? {busy_q, ac_q} : 8'h00;
  assign o_busy      = busy_q;
  assign o_evt_valid = evt_v_q;
  assign o_evt_rs    = evt_rs_q;
  assign o_evt_byte  = evt_byte_q;
  assign o_disp_on   = disp_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed bench with event scoreboard for lcd_hd44780_responder
module tb_lcd_hd44780_responder;
`ifdef LCD_BUSY_MODEL_EN
  localparam bit BM = 1'b1;
`else
  localparam bit BM = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] o_rd_char, o_evt_byte;
  logic       o_busy, o_evt_valid, o_evt_rs, o_disp_on, o_err;
  int         checks = 0;
  int         failures = 0;
  logic [8:0] evq[$];

  lcd_hd44780_responder_if bus ();

  lcd_hd44780_responder #(.CLK_FREQ(1_000_000), .CMD_US(40), .CLEAR_US(1640)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .lcd         (bus),
    .i_rd_idx    (rd_idx),
    .o_rd_char   (o_rd_char),
    .o_busy      (o_busy),
    .o_evt_valid (o_evt_valid),
    .o_evt_rs    (o_evt_rs),
    .o_evt_byte  (o_evt_byte),
    .o_disp_on   (o_disp_on),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d, input bit acc);
    if (acc) evq.push_back({rs, d});
    @(negedge clk);
    bus.lcd_rs = rs;
    bus.lcd_rw = 1'b0;
    bus.lcd_data = d;
    bus.lcd_e = 1'b1;
    @(negedge clk);
    bus.lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_bound", 32'(n < 5000), 32'd1);
  endtask

  task automatic read_ac(output logic [7:0] v);
    @(negedge clk);
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b1;
    bus.lcd_e = 1'b1;
    #1 v = bus.lcd_dq;
    @(negedge clk);
    bus.lcd_e = 1'b0;
    @(negedge clk);
    bus.lcd_rw = 1'b0;
  endtask

  task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rd_idx = idx;
    @(negedge clk);
    chk(tag, 32'(o_rd_char), exp);
  endtask

  // scoreboard: every accepted write pulse must match the oldest expected transfer
  always @(negedge clk) begin
    if (!rst && o_evt_valid) begin
      chk("evt_expected", 32'(evq.size() != 0), 32'd1);
      if (evq.size() != 0) chk("evt", 32'({o_evt_rs, o_evt_byte}), 32'(evq.pop_front()));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] v;
    bus.lcd_e = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rd_char", 32'(o_rd_char), 32'h00);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_disp_on", 32'(o_disp_on), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_evt", 32'(o_evt_valid), 32'd0);
    for (int i = 0; i < 32; i++) rd(5'(i), 32'h20, "init_fill");
    read_ac(v); chk("rst_ac", 32'(v), 32'h00);
    wr(1'b0, 8'h0C, 1'b1); wait_idle(n);
    chk("busy_cmd_cycles", 32'(n), BM ? 32'd40 : 32'd0);
    chk("disp_on", 32'(o_disp_on), 32'd1);
    wr(1'b1, 8'h41, 1'b1); wait_idle(n);
    rd(5'd0, 32'h41, "ddram0_A");
    read_ac(v); chk("ac_after_A", 32'(v), 32'h01);
    wr(1'b0, 8'h8F, 1'b1); wait_idle(n);
    wr(1'b1, 8'h58, 1'b1); wait_idle(n);
    wr(1'b1, 8'h59, 1'b1); wait_idle(n);
    rd(5'd15, 32'h58, "ddram15_X");
    rd(5'd16, 32'h59, "ddram16_Y_wrap");
    read_ac(v); chk("ac_after_wrap", 32'(v), 32'h41);
    wr(1'b0, 8'hCF, 1'b1); wait_idle(n);
    wr(1'b1, 8'h5A, 1'b1); wait_idle(n);
    rd(5'd31, 32'h5A, "ddram31_Z");
    read_ac(v); chk("ac_wrap_4f", 32'(v), 32'h00);
    wr(1'b0, 8'h04, 1'b1); wait_idle(n);
    wr(1'b0, 8'h85, 1'b1); wait_idle(n);
    wr(1'b1, 8'h51, 1'b1); wait_idle(n);
    rd(5'd5, 32'h51, "ddram5_Q");
    read_ac(v); chk("ac_decrement", 32'(v), 32'h04);
    wr(1'b0, 8'h06, 1'b1); wait_idle(n);
    wr(1'b0, 8'h80, 1'b1); wait_idle(n);
    wr(1'b1, 8'h42, 1'b1);
    repeat (3) @(negedge clk);
    read_ac(v); chk("dq_while_busy", 32'(v), 32'({BM, 7'h01}));
    wr(1'b1, 8'h43, !BM); wait_idle(n);
    chk("err_drop", 32'(o_err), 32'(BM));
    rd(5'd1, BM ? 32'h20 : 32'h43, "ddram1_C");
    read_ac(v); chk("ac_after_drop", 32'(v), BM ? 32'h01 : 32'h02);
    wr(1'b0, 8'hA5, 1'b1); wait_idle(n);
    chk("err_illegal_addr", 32'(o_err), 32'd1);
    read_ac(v); chk("ac_illegal_fold", 32'(v), 32'h05);
    wr(1'b0, 8'h80, 1'b1); wait_idle(n);
    wr(1'b0, 8'h10, 1'b1); wait_idle(n);
    read_ac(v); chk("shift_left_wrap", 32'(v), 32'h4F);
    wr(1'b0, 8'h14, 1'b1); wait_idle(n);
    wr(1'b0, 8'h1C, 1'b1); wait_idle(n);
    read_ac(v); chk("shift_right_wrap", 32'(v), 32'h00);
    wr(1'b0, 8'h00, 1'b0);
    chk("noop_busy", 32'(o_busy), 32'd0);
    wr(1'b0, 8'h83, 1'b1); wait_idle(n);
    wr(1'b0, 8'h02, 1'b1); wait_idle(n);
    chk("busy_home_cycles", 32'(n), BM ? 32'd1640 : 32'd0);
    read_ac(v); chk("ac_home", 32'(v), 32'h00);
    wr(1'b0, 8'h04, 1'b1); wait_idle(n);
    wr(1'b0, 8'h01, 1'b1); wait_idle(n);
    chk("busy_clear_cycles", 32'(n), BM ? 32'd1640 : 32'd0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 32; i++) rd(5'(i), 32'h20, "clear_fill");
    read_ac(v); chk("ac_clear", 32'(v), 32'h00);
    wr(1'b0, 8'h04, 1'b1); wait_idle(n);
    wr(1'b0, 8'h01, 1'b1);
    repeat (5) @(negedge clk);
    wr(1'b1, 8'h4B, !BM);
    repeat (40) @(negedge clk);
    wait_idle(n);
    rd(5'd0, BM ? 32'h20 : 32'h4B, "held_during_fill");
    read_ac(v); chk("ac_after_fill_inc", 32'(v), BM ? 32'h00 : 32'h01);
    wr(1'b0, 8'h01, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midclear_rst_busy", 32'(o_busy), 32'd0);
    chk("midclear_rst_rd", 32'(o_rd_char), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_err", 32'(o_err), 32'd0);
    chk("post_rst_disp", 32'(o_disp_on), 32'd0);
    rd(5'd31, 32'h20, "post_rst_fill");
    read_ac(v); chk("post_rst_ac", 32'(v), 32'h00);
    wr(1'b1, 8'h4D, 1'b1); wait_idle(n);
    chk("post_rst_busy_cycles", 32'(n), BM ? 32'd40 : 32'd0);
    rd(5'd0, 32'h4D, "post_rst_write");
    repeat (4) @(negedge clk);
    chk("evq_drained", 32'(evq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
